// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised N-digit BCD up/down counter for the stopwatch/timer datapath.
//
// Counts in packed BCD between 0 and a configurable terminal value MAX_BCD. It can wrap
// at the terminal, or saturate there. It supports synchronous clear and a validated
// parallel load. Stages cascade through ena_in/ena_out to build longer chains, for
// example hundredths -> seconds -> minutes -> hours.
//
// Parameters:
//   NDIG     number of BCD digits (1..8)
//   MAX_BCD  terminal value in BCD, 4*NDIG bits; every nibble must be <= 9
//   WRAP     1 = wrap at terminal, 0 = saturate at terminal
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active high
//   clear     in   synchronous clear to zero (highest priority)
//   ena_in    in   count enable / cascade carry-in
//   up_dn     in   direction: 1 = up, 0 = down
//   load      in   synchronous parallel load request
//   load_val  in   BCD load value
//   count     out  current BCD value; digit i at bits [4i+3:4i]
//   tc        out  terminal flag for the current direction (combinational)
//   ena_out   out  cascade carry-out: ena_in & tc & WRAP (combinational)
//   sat       out  saturation flag: tc when WRAP == 0 (combinational)
//   load_err  out  one-cycle registered pulse when a load is rejected
module bcd_counter_n #(
  parameter int unsigned         NDIG    = 2,
  parameter logic [4*NDIG-1:0]   MAX_BCD = 8'h59,
  parameter bit                  WRAP    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ena_in,
  input  logic              up_dn,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] count,
  output logic              tc,
  output logic              ena_out,
  output logic              sat,
  output logic              load_err
);

  localparam int unsigned W = 4 * NDIG;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NDIG == 0 || NDIG > 8) begin : g_bad_ndig
    $error("bcd_counter_n: NDIG must be in 1..8");
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_max_chk
    if (MAX_BCD[4*g +: 4] > 4'd9) begin : g_bad_max
      $error("bcd_counter_n: MAX_BCD contains a non-BCD nibble");
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0] count_q, count_d;
  logic         load_err_q, load_err_d;

  // ---------------------------------------------------------------------------
  // Per-digit increment / decrement chains
  // ---------------------------------------------------------------------------
  // all9[i]: every digit below i is 9, so digit i steps on an increment.
  // all0[i]: every digit below i is 0, so digit i steps on a decrement.
  logic [NDIG:0]   all9;
  logic [NDIG:0]   all0;
  logic [W-1:0]    inc_val;
  logic [W-1:0]    dec_val;
  logic [NDIG-1:0] lv_nib_ok;

  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    logic [3:0] dig;
    logic [3:0] lv_dig;

    assign dig    = count_q[4*i +: 4];
    assign lv_dig = load_val[4*i +: 4];

    assign all9[i+1] = all9[i] & (dig == 4'd9);
    assign all0[i+1] = all0[i] & (dig == 4'd0);

    assign inc_val[4*i +: 4] = !all9[i]      ? dig :
                               (dig == 4'd9) ? 4'd0 : dig + 4'd1;
    assign dec_val[4*i +: 4] = !all0[i]      ? dig :
                               (dig == 4'd0) ? 4'd9 : dig - 4'd1;

    assign lv_nib_ok[i] = (lv_dig <= 4'd9);
  end

  // ---------------------------------------------------------------------------
  // Terminal detection and load validation
  // ---------------------------------------------------------------------------
  logic at_max;
  logic at_zero;
  logic load_ok;

  assign at_max  = (count_q == MAX_BCD);
  assign at_zero = (count_q == '0);

  // For well-formed BCD an unsigned vector compare orders the same as the decimal value.
  assign load_ok = (&lv_nib_ok) && (load_val <= MAX_BCD);

  // ---------------------------------------------------------------------------
  // Next-state logic: clear > load > ena_in > hold
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;

    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (ena_in) begin
      if (up_dn) begin
        // Full-vector compare so non-decimal terminals such as 23 wrap correctly.
        if (at_max) begin
          count_d = WRAP ? '0 : MAX_BCD;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (at_zero) begin
          count_d = WRAP ? MAX_BCD : '0;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count    = count_q;
  assign tc       = (up_dn & at_max) | (~up_dn & at_zero);
  assign ena_out  = ena_in & tc & WRAP;
  assign sat      = ~WRAP & tc;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n.
// Three instances share control inputs:
//   a: 2 digits, terminal 59, wrapping
//   s: 3 digits, terminal 999, saturating
//   h: 2 digits, terminal 23, wrapping
// Expected values come from an integer-valued reference model.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        ena_in = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  lv_a, lv_h;
  logic [11:0] lv_s;
  logic [7:0]  cnt_a, cnt_h;
  logic [11:0] cnt_s;
  logic        tc_a, eo_a, sat_a, le_a;
  logic        tc_s, eo_s, sat_s, le_s;
  logic        tc_h, eo_h, sat_h, le_h;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: counter value as a plain integer, plus the expected load_err.
  int m_a = 0, m_s = 0, m_h = 0;
  bit e_a = 0, e_s = 0, e_h = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.NDIG(2), .MAX_BCD(8'h59), .WRAP(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .clear(clear), .ena_in(ena_in), .up_dn(up_dn), .load(load),
    .load_val(lv_a), .count(cnt_a), .tc(tc_a), .ena_out(eo_a), .sat(sat_a), .load_err(le_a)
  );

  bcd_counter_n #(.NDIG(3), .MAX_BCD(12'h999), .WRAP(1'b0)) u_dut_s (
    .clk(clk), .rst(rst), .clear(clear), .ena_in(ena_in), .up_dn(up_dn), .load(load),
    .load_val(lv_s), .count(cnt_s), .tc(tc_s), .ena_out(eo_s), .sat(sat_s), .load_err(le_s)
  );

  bcd_counter_n #(.NDIG(2), .MAX_BCD(8'h23), .WRAP(1'b1)) u_dut_h (
    .clk(clk), .rst(rst), .clear(clear), .ena_in(ena_in), .up_dn(up_dn), .load(load),
    .load_val(lv_h), .count(cnt_h), .tc(tc_h), .ena_out(eo_h), .sat(sat_h), .load_err(le_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [31:0] b, input int nd);
    int v;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit ok_load(input logic [31:0] b, input int nd, input int mx);
    for (int i = 0; i < nd; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return from_bcd(b, nd) <= mx;
  endfunction

  // Next model value from the current control inputs.
  function automatic int nxt(input int c, input int mx, input bit wr, input int nd,
                             input logic [31:0] lv, output bit err);
    err = 1'b0;
    if (clear) return 0;
    if (load) begin
      if (ok_load(lv, nd, mx)) return from_bcd(lv, nd);
      err = 1'b1;
      return c;
    end
    if (ena_in) begin
      if (up_dn) return (c == mx) ? (wr ? 0 : mx) : c + 1;
      else       return (c == 0)  ? (wr ? mx : 0) : c - 1;
    end
    return c;
  endfunction

  task automatic chk_dut(input string nm, input logic [31:0] cnt, input logic tc,
                         input logic eo, input logic st, input logic le,
                         input int m, input int mx, input bit wr, input bit e);
    bit tc_exp;
    tc_exp = (up_dn && m == mx) || (!up_dn && m == 0);
    check({nm, ".count"},    cnt,         to_bcd(m));
    check({nm, ".tc"},       32'(tc),     32'(tc_exp));
    check({nm, ".ena_out"},  32'(eo),     32'(ena_in && tc_exp && wr));
    check({nm, ".sat"},      32'(st),     32'(!wr && tc_exp));
    check({nm, ".load_err"}, 32'(le),     32'(e));
  endtask

  task automatic check_all();
    chk_dut("a", 32'(cnt_a), tc_a, eo_a, sat_a, le_a, m_a, 59,  1'b1, e_a);
    chk_dut("s", 32'(cnt_s), tc_s, eo_s, sat_s, le_s, m_s, 999, 1'b0, e_s);
    chk_dut("h", 32'(cnt_h), tc_h, eo_h, sat_h, le_h, m_h, 23,  1'b1, e_h);
  endtask

  // One clock cycle: drive just after the falling edge, check, then advance the model.
  task automatic cyc(input bit clr, input bit ld, input logic [31:0] lv,
                     input bit en, input bit up);
    clear  = clr;
    load   = ld;
    lv_a   = lv[7:0];
    lv_s   = lv[11:0];
    lv_h   = lv[7:0];
    ena_in = en;
    up_dn  = up;
    #1;
    check_all();
    @(posedge clk);
    if (rst) begin
      m_a = 0; m_s = 0; m_h = 0;
      e_a = 0; e_s = 0; e_h = 0;
    end else begin
      m_a = nxt(m_a, 59,  1'b1, 2, {24'h0, lv[7:0]},  e_a);
      m_s = nxt(m_s, 999, 1'b0, 3, {20'h0, lv[11:0]}, e_s);
      m_h = nxt(m_h, 23,  1'b1, 2, {24'h0, lv[7:0]},  e_h);
    end
    @(negedge clk);
  endtask

  initial begin
    bit          up_r;
    logic [31:0] lv_r;

    lv_a = '0; lv_s = '0; lv_h = '0;

    // Reset state.
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Up count through the full range: 59 -> 00 on a, 23 -> 00 on h.
    for (int i = 0; i < 62; i++) cyc(0, 0, 0, 1, 1);

    // Down wrap from 01 through 00 into the terminal, then a digit borrow at 50.
    cyc(0, 1, 32'h001, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 32'h050, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0);

    // Load validation: non-BCD nibble, above terminal, valid.
    cyc(0, 1, 32'h05A, 0, 1);
    cyc(0, 1, 32'h060, 0, 1);
    cyc(0, 1, 32'h037, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Saturation at 999, then step back down.
    cyc(0, 1, 32'h998, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Priority: clear over load over enable.
    cyc(1, 1, 32'h025, 1, 1);
    cyc(0, 1, 32'h025, 1, 1);
    cyc(0, 0, 0, 0, 1);

    // Asynchronous reset asserted between edges while counting from 42.
    cyc(0, 1, 32'h042, 0, 1);
    clear = 0; load = 0; ena_in = 1; up_dn = 1;
    #2;
    rst = 1'b1;
    #1;
    m_a = 0; m_s = 0; m_h = 0;
    e_a = 0; e_s = 0; e_h = 0;
    check_all();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);

    // Hour terminal: 22 -> 23 -> 00 -> 01.
    cyc(0, 1, 32'h022, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);

    // Randomised traffic.
    up_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) up_r = ~up_r;
      if ($urandom_range(0, 2) == 0) lv_r = $urandom;
      else                           lv_r = to_bcd(int'($urandom_range(0, 1000)));
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0, lv_r,
          $urandom_range(0, 3) != 0, up_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
